// File: rtl/quad_pkg.sv
// Shared types, Gray-sequence constants and phase stepping for the quadrature generator.
package quad_pkg;
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic DIR_CW  = 1'b1;
    localparam logic DIR_CCW = 1'b0;

    // Index 0 is the rest phase {a,b}=00; each step walks indices 0..3 and back to 0.
    localparam logic [3:0][1:0] CW_SEQ  = {2'b01, 2'b11, 2'b10, 2'b00};
    localparam logic [3:0][1:0] CCW_SEQ = {2'b10, 2'b11, 2'b01, 2'b00};

    function automatic logic [1:0] next_phase(input logic [1:0] phase, input logic dir);
        logic [3:0][1:0] seq;
        logic [1:0]      nxt;
        seq = (dir == DIR_CW) ? CW_SEQ : CCW_SEQ;
        nxt = seq[1];
        for (int i = 0; i < 4; i++)
            if (seq[i] == phase) nxt = seq[2'(i + 1)];
        return nxt;
    endfunction
endpackage

// File: rtl/quad_edge_timer.sv
// Reloadable down-counter; tick is high for one cycle each time the count expires while enabled.
module quad_edge_timer #(
    parameter int EDGE_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic tick
);
    localparam int W = $clog2(EDGE_DIV + 1);
    localparam logic [W-1:0] RELOAD = W'(EDGE_DIV - 1);

    logic [W-1:0] cnt;

    assign tick = en && (cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          cnt <= '0;
        else if (load)       cnt <= RELOAD;
        else if (en)         cnt <= (cnt == '0) ? RELOAD : cnt - 1'b1;
    end
endmodule

// File: rtl/quad_generator.sv
// Quadrature A/B generator fed by a saturating signed pending-step counter.
// Optional index output z and position counter enabled with `define QGEN_INDEX_EN.
module quad_generator
    import quad_pkg::*;
#(
    parameter int EDGE_DIV = 4,
    parameter int PEND_W   = 4
`ifdef QGEN_INDEX_EN
    ,
    parameter int STEPS_PER_REV = 100
`endif
) (
    input  logic clk,
    input  logic rst_n,
    input  logic step_cw,
    input  logic step_ccw,
    output logic a,
    output logic b,
    output logic busy,
    output logic ovf
`ifdef QGEN_INDEX_EN
    ,
    output logic z
`endif
);
    localparam logic signed [PEND_W-1:0] P_MAX = {1'b0, {(PEND_W-1){1'b1}}};
    localparam logic signed [PEND_W-1:0] P_MIN = {1'b1, {(PEND_W-1){1'b0}}};

    state_t                    state, state_nxt;
    logic signed [PEND_W-1:0]  pend, pend_nxt;
    logic [1:0]                ab;
    logic [1:0]                edge_cnt;
    logic                      dir;
    logic                      tick, inc, dec, drop, last_edge, claim;

    quad_edge_timer #(.EDGE_DIV(EDGE_DIV)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (claim),
        .en    (state == RUN),
        .tick  (tick)
    );

    always_comb begin
        inc       = step_cw & ~step_ccw;
        dec       = step_ccw & ~step_cw;
        drop      = (inc && pend == P_MAX) || (dec && pend == P_MIN);
        last_edge = (state == RUN) && tick && (edge_cnt == 2'd3);
        claim     = (pend != '0) && ((state == IDLE) || last_edge);
        pend_nxt  = pend;
        if (inc && !drop) pend_nxt = pend_nxt + PEND_W'(1);
        if (dec && !drop) pend_nxt = pend_nxt - PEND_W'(1);
        // Claiming moves P toward zero; saturation was resolved on the current P above.
        if (claim) pend_nxt = pend[PEND_W-1] ? pend_nxt + PEND_W'(1) : pend_nxt - PEND_W'(1);
        state_nxt = state;
        case (state)
            IDLE:    if (claim) state_nxt = RUN;
            RUN:     if (last_edge && !claim) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pend     <= '0;
            ab       <= 2'b00;
            edge_cnt <= 2'd0;
            dir      <= DIR_CW;
            ovf      <= 1'b0;
        end else begin
            state <= state_nxt;
            pend  <= pend_nxt;
            ovf   <= drop;
            if (state == RUN && tick) ab <= next_phase(ab, dir);
            if (claim) begin
                edge_cnt <= 2'd0;
                dir      <= pend[PEND_W-1] ? DIR_CCW : DIR_CW;
            end else if (state == RUN && tick) begin
                edge_cnt <= edge_cnt + 2'd1;
            end
        end
    end

    assign a    = ab[1];
    assign b    = ab[0];
    assign busy = (state == RUN);

`ifdef QGEN_INDEX_EN
    localparam int POS_W = (STEPS_PER_REV > 1) ? $clog2(STEPS_PER_REV) : 1;
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(STEPS_PER_REV - 1);

    logic [POS_W-1:0] pos, pos_nxt;

    always_comb begin
        if (dir == DIR_CW) pos_nxt = (pos == POS_LAST) ? '0 : pos + 1'b1;
        else               pos_nxt = (pos == '0) ? POS_LAST : pos - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos <= '0;
            z   <= 1'b0;
        end else begin
            z <= last_edge && (pos_nxt == '0);
            if (last_edge) pos <= pos_nxt;
        end
    end
`endif
endmodule
